// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue/writeback front end: opcodes, FSM states, default width.
package alu_pkg;

  localparam int unsigned ALU_DATA_W = 32;

  localparam logic [3:0] OP_LSLA = 4'd0;
  localparam logic [3:0] OP_LSRL = 4'd1;
  localparam logic [3:0] OP_ASR  = 4'd2;
  localparam logic [3:0] OP_ROL  = 4'd3;
  localparam logic [3:0] OP_AND  = 4'd4;
  localparam logic [3:0] OP_OR   = 4'd5;
  localparam logic [3:0] OP_XOR  = 4'd6;
  localparam logic [3:0] OP_NOT  = 4'd7;
  localparam logic [3:0] OP_ADD  = 4'd8;
  localparam logic [3:0] OP_SUB  = 4'd9;
  localparam logic [3:0] OP_LOAD = 4'hF;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StCapture
  } issue_state_e;

  function automatic logic is_alu_op(input logic [3:0] op);
    return op <= OP_SUB;
  endfunction

endpackage

// File: rtl/alu_regfile.sv
// General register file: two combinational operand reads, one debug read, one synchronous write.
module alu_regfile #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned NREGS  = 8,
  parameter int unsigned AW     = 3
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [AW-1:0]     raddr_a_i,
  output logic [DATA_W-1:0] rdata_a_o,
  input  logic [AW-1:0]     raddr_b_i,
  output logic [DATA_W-1:0] rdata_b_o,
  input  logic [AW-1:0]     dbg_addr_i,
  output logic [DATA_W-1:0] dbg_data_o
);

  logic [DATA_W-1:0] regs_q [NREGS];
  logic [DATA_W-1:0] regs_d [NREGS];

  always_comb begin
    regs_d = regs_q;
    if (we_i) regs_d[waddr_i] = wdata_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  // Reads see pre-write contents; a same-cycle write lands at the edge.
  assign rdata_a_o  = regs_q[raddr_a_i];
  assign rdata_b_o  = regs_q[raddr_b_i];
  assign dbg_data_o = regs_q[dbg_addr_i];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Command front end for the registered ALU: operand fetch, issue, result capture and writeback.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int unsigned DATA_W = ALU_DATA_W,
  parameter int unsigned NREGS  = 8,
  parameter int unsigned AW     = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [3:0]        cmd_op,
  input  logic [AW-1:0]     cmd_dst,
  input  logic [AW-1:0]     cmd_srca,
  input  logic [AW-1:0]     cmd_srcb,
  input  logic [DATA_W-1:0] cmd_imm,
  output logic [DATA_W-1:0] alu_port_a,
  output logic [DATA_W-1:0] alu_port_b,
  output logic [3:0]        alu_opcode,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_negative,
  input  logic              alu_zero,
  input  logic              alu_carry,
  output logic              flag_n,
  output logic              flag_z,
  output logic              flag_c,
  output logic              done,
  output logic              err,
  input  logic [AW-1:0]     dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  issue_state_e      state_q, state_d;
  logic [AW-1:0]     dst_q, dst_d;
  logic [DATA_W-1:0] port_a_q, port_a_d, port_b_q, port_b_d;
  logic [3:0]        opcode_q, opcode_d;
  logic [2:0]        flags_q, flags_d;
  logic              done_q, done_d, err_q, err_d;

  logic              accept, is_load;
  logic              rf_we;
  logic [AW-1:0]     rf_waddr;
  logic [DATA_W-1:0] rf_wdata, rd_a, rd_b;

  assign cmd_ready = (state_q == StIdle);
  assign accept    = cmd_valid & cmd_ready;
  assign is_load   = (cmd_op == OP_LOAD);

  always_comb begin
    state_d  = state_q;
    dst_d    = dst_q;
    port_a_d = port_a_q;
    port_b_d = port_b_q;
    opcode_d = opcode_q;
    flags_d  = flags_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (is_alu_op(cmd_op)) begin
            port_a_d = rd_a;
            port_b_d = rd_b;
            opcode_d = cmd_op;
            dst_d    = cmd_dst;
            state_d  = StIssue;
          end else if (is_load) begin
            done_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      StIssue: state_d = StCapture;
      StCapture: begin
        flags_d = {alu_negative, alu_zero, alu_carry};
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      dst_q    <= '0;
      port_a_q <= '0;
      port_b_q <= '0;
      opcode_q <= '0;
      flags_q  <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      dst_q    <= dst_d;
      port_a_q <= port_a_d;
      port_b_q <= port_b_d;
      opcode_q <= opcode_d;
      flags_q  <= flags_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  // LOAD writes only from Idle and ALU writeback only from Capture, so they never collide.
  assign rf_we    = (accept & is_load) | (state_q == StCapture);
  assign rf_waddr = (state_q == StCapture) ? dst_q : cmd_dst;
  assign rf_wdata = (state_q == StCapture) ? alu_result : cmd_imm;

  alu_regfile #(
    .DATA_W(DATA_W),
    .NREGS (NREGS),
    .AW    (AW)
  ) u_regfile (
    .clk_i     (clk),
    .rst_i     (rst),
    .we_i      (rf_we),
    .waddr_i   (rf_waddr),
    .wdata_i   (rf_wdata),
    .raddr_a_i (cmd_srca),
    .rdata_a_o (rd_a),
    .raddr_b_i (cmd_srcb),
    .rdata_b_o (rd_b),
    .dbg_addr_i(dbg_addr),
    .dbg_data_o(dbg_data)
  );

  assign alu_port_a = port_a_q;
  assign alu_port_b = port_b_q;
  assign alu_opcode = opcode_q;
  assign flag_n     = flags_q[2];
  assign flag_z     = flags_q[1];
  assign flag_c     = flags_q[0];
  assign done       = done_q;
  assign err        = err_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a registered ADD/SUB ALU model alongside.
module tb_alu_issue_ctrl;

  logic        clk, rst;
  logic        cmd_valid, cmd_ready;
  logic [3:0]  cmd_op;
  logic [2:0]  cmd_dst, cmd_srca, cmd_srcb, dbg_addr;
  logic [31:0] cmd_imm, alu_port_a, alu_port_b, alu_result, dbg_data;
  logic [3:0]  alu_opcode;
  logic        alu_negative, alu_zero, alu_carry;
  logic        flag_n, flag_z, flag_c, done, err;

  int checks = 0;
  int failures = 0;

  alu_issue_ctrl dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_dst(cmd_dst), .cmd_srca(cmd_srca), .cmd_srcb(cmd_srcb), .cmd_imm(cmd_imm),
    .alu_port_a(alu_port_a), .alu_port_b(alu_port_b), .alu_opcode(alu_opcode),
    .alu_result(alu_result), .alu_negative(alu_negative), .alu_zero(alu_zero),
    .alu_carry(alu_carry),
    .flag_n(flag_n), .flag_z(flag_z), .flag_c(flag_c),
    .done(done), .err(err), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered ALU stand-in; only ADD and SUB are exercised, carry is carry-out / borrow.
  logic [32:0] alu_wide;
  always_comb begin
    alu_wide = {1'b0, alu_port_a};
    if (alu_opcode == 4'd8) alu_wide = {1'b0, alu_port_a} + {1'b0, alu_port_b};
    else if (alu_opcode == 4'd9) alu_wide = {1'b0, alu_port_a} - {1'b0, alu_port_b};
  end
  always @(posedge clk) begin
    alu_result   <= alu_wide[31:0];
    alu_negative <= alu_wide[31];
    alu_zero     <= (alu_wide[31:0] == 32'd0);
    alu_carry    <= alu_wide[32];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic check_reg(input string tag, input logic [2:0] addr, input logic [31:0] exp);
    dbg_addr = addr;
    #1;
    check(tag, dbg_data, exp);
  endtask

  task automatic check_flags(input string tag, input logic [2:0] exp);
    check(tag, {29'd0, flag_n, flag_z, flag_c}, {29'd0, exp});
  endtask

  // Drives one command at posedge+1, then waits (bounded) for done and checks latency and busy cycles.
  task automatic do_cmd(input string tag, input logic [3:0] op, input logic [2:0] dst,
                        input logic [2:0] a, input logic [2:0] b, input logic [31:0] imm,
                        input int exp_lat);
    int n;
    int busy;
    check({tag, "_rdy"}, {31'd0, cmd_ready}, 32'd1);
    cmd_valid = 1'b1; cmd_op = op; cmd_dst = dst; cmd_srca = a; cmd_srcb = b; cmd_imm = imm;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    n = 1;
    busy = 0;
    while (!done && n < 8) begin
      if (!cmd_ready) busy++;
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_lat"}, n, exp_lat);
    check({tag, "_busy"}, busy, exp_lat - 1);
  endtask

  initial begin
    bit saw_done;
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_dst = '0; cmd_srca = '0; cmd_srcb = '0;
    cmd_imm = '0; dbg_addr = '0;
    @(posedge clk); #1;
    check("rst_ready", {31'd0, cmd_ready}, 32'd1);
    check("rst_done_err", {30'd0, done, err}, 32'd0);
    check("rst_port_a", alu_port_a, 32'd0);
    check("rst_port_b", alu_port_b, 32'd0);
    check_flags("rst_flags", 3'b000);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 8; i++) check_reg("rst_reg", 3'(i), 32'd0);

    // Back-to-back LOADs
    do_cmd("load_r1", 4'hF, 3'd1, 3'd0, 3'd0, 32'd5, 1);
    do_cmd("load_r2", 4'hF, 3'd2, 3'd0, 3'd0, 32'd3, 1);
    check_reg("r1", 3'd1, 32'h0000_0005);
    check_reg("r2", 3'd2, 32'h0000_0003);
    check_flags("load_flags", 3'b000);

    do_cmd("add_r3", 4'd8, 3'd3, 3'd1, 3'd2, 32'd0, 3);
    check_reg("r3", 3'd3, 32'h0000_0008);
    check_flags("add_flags", 3'b000);
    check("hold_port_a", alu_port_a, 32'd5);
    check("hold_port_b", alu_port_b, 32'd3);
    check("hold_opcode", {28'd0, alu_opcode}, 32'd8);

    do_cmd("sub_r4", 4'd9, 3'd4, 3'd2, 3'd1, 32'd0, 3);
    check_reg("r4", 3'd4, 32'hFFFF_FFFE);
    check_flags("sub_flags", 3'b101);

    // Illegal opcode with N=1 already set
    cmd_valid = 1'b1; cmd_op = 4'hA; cmd_dst = 3'd4; cmd_imm = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    check("ill_err", {31'd0, err}, 32'd1);
    check("ill_done", {31'd0, done}, 32'd0);
    check("ill_ready", {31'd0, cmd_ready}, 32'd1);
    @(posedge clk); #1;
    check("ill_err_clr", {31'd0, err}, 32'd0);
    check_reg("ill_r4", 3'd4, 32'hFFFF_FFFE);
    check_reg("ill_r1", 3'd1, 32'h0000_0005);
    check_flags("ill_flags", 3'b101);

    do_cmd("load_r5", 4'hF, 3'd5, 3'd0, 3'd0, 32'hFFFF_FFFF, 1);
    do_cmd("load_r6", 4'hF, 3'd6, 3'd0, 3'd0, 32'd1, 1);

    // ADD r7=r5+r6 with a LOAD r0 held valid while busy
    cmd_valid = 1'b1; cmd_op = 4'd8; cmd_dst = 3'd7; cmd_srca = 3'd5; cmd_srcb = 3'd6;
    @(posedge clk); #1;
    cmd_op = 4'hF; cmd_dst = 3'd0; cmd_imm = 32'h0000_1234;
    check("busy_rdy0", {31'd0, cmd_ready}, 32'd0);
    @(posedge clk); #1;
    check("busy_rdy1", {31'd0, cmd_ready}, 32'd0);
    check_reg("busy_r0a", 3'd0, 32'd0);
    @(posedge clk); #1;
    check("busy_add_done", {31'd0, done}, 32'd1);
    check("busy_rdy2", {31'd0, cmd_ready}, 32'd1);
    check_reg("busy_r0b", 3'd0, 32'd0);
    check_reg("r7", 3'd7, 32'd0);
    check_flags("add_wrap_flags", 3'b011);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    check("busy_load_done", {31'd0, done}, 32'd1);
    check_reg("busy_r0c", 3'd0, 32'h0000_1234);
    @(posedge clk); #1;
    check("busy_done_clr", {31'd0, done}, 32'd0);

    // Reset during CAPTURE of ADD r3
    cmd_valid = 1'b1; cmd_op = 4'd8; cmd_dst = 3'd3; cmd_srca = 3'd1; cmd_srcb = 3'd2;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(posedge clk); #1;
    check("abort_busy", {31'd0, cmd_ready}, 32'd0);
    rst = 1'b1;
    #1;
    check("abort_rdy_in_rst", {31'd0, cmd_ready}, 32'd1);
    saw_done = done;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (done) saw_done = 1'b1;
      @(posedge clk); #1;
    end
    check("abort_no_done", {31'd0, saw_done}, 32'd0);
    check("abort_ready", {31'd0, cmd_ready}, 32'd1);
    check_reg("abort_r3", 3'd3, 32'd0);
    check_reg("abort_r5", 3'd5, 32'd0);
    check_flags("abort_flags", 3'b000);
    check("abort_port_a", alu_port_a, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
